peripheral_mpram_master: RTL and testbench
==========================================

PERIPHERAL_MPRAM_MASTER -- requirements
Module: peripheral_mpram_master

Interface
REQ-001 Parameter ADDR_MSB, default 6: MSB of the RAM word-address bus.
REQ-002 Parameter MEM_SIZE, default 256: RAM size in bytes; word count is MEM_SIZE/2.
REQ-003 The block SHALL use one clock, mclk, and a synchronous, active-high reset, puc_rst.
REQ-004 mclk  input  1  system clock; all state changes on the rising edge.
REQ-005 puc_rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted on an edge where req_valid & req_ready.
REQ-008 req_we  input  1  1=write, 0=read.
REQ-009 req_be  input  2  byte enables, active high; [1]=high byte, [0]=low byte; writes only.
REQ-010 req_addr  input  ADDR_MSB+2  byte address; bit 0 ignored.
REQ-011 req_wdata  input  16  write data.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  response consumed on an edge where rsp_valid & rsp_ready.
REQ-014 rsp_rdata  output  16  read data; 0 for writes and errors.
REQ-015 rsp_err  output  1  out-of-range access.
REQ-016 ram_addr  output  ADDR_MSB+1  RAM word address, registered.
REQ-017 ram_cen  output  1  RAM chip enable, active low, registered.
REQ-018 ram_wen  output  2  RAM write enable, active low, registered.
REQ-019 ram_din  output  16  RAM write data, registered.
REQ-020 ram_dout  input  16  RAM read data, valid one cycle after the sampling edge.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, CAPTURE and RESP; req_ready SHALL equal (state==IDLE) & ~puc_rst.
REQ-022 On accept, the block SHALL register ram_addr=req_addr[ADDR_MSB+1:1] and ram_din=req_wdata.
REQ-023 On accept, it SHALL set ram_wen=~req_be for a write and 2'b11 for a read.
REQ-024 Out-of-range accept: word index >= MEM_SIZE/2 -> RESP, rsp_err=1, rsp_rdata=0, ram_cen held high.
REQ-025 Write with req_be=2'b00 -> RESP next cycle, rsp_err=0, no RAM access.
REQ-026 Other accepts -> ACCESS; ram_cen=0 for exactly that one cycle and high in every other state.
REQ-027 ACCESS -> CAPTURE for reads; ACCESS -> RESP for writes, with rsp_rdata=0.
REQ-028 CAPTURE SHALL latch ram_dout into rsp_rdata at the cycle end -> RESP.
REQ-029 Latency from the accept edge to rsp_valid: read 3 cycles, write 2 cycles, error or be=00 write 1 cycle.
REQ-030 RESP: rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_ready; on the handshake edge -> IDLE, rsp_valid=0.
REQ-031 Exactly one request outstanding; no new request is accepted in the handshake cycle.
REQ-032 ram_addr and ram_din SHALL hold their value after ACCESS until the next accept, keeping ram_dout stable.
REQ-033 ram_wen SHALL return to 2'b11 after ACCESS.

Reset
REQ-034 When puc_rst is high at an edge: state=IDLE, ram_cen=1, ram_wen=2'b11, ram_addr=0, ram_din=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-035 Reset mid-operation SHALL abort the transaction; any pending response SHALL be discarded; a write in ACCESS may already have been sampled by the RAM.
REQ-036 Reset SHALL take priority over every simultaneous handshake.

Structure
REQ-037 The shared package peripheral_mpram_pkg SHALL hold the FSM state enum, RAM_WEN_NONE=2'b11 and DATA_W=16.
REQ-038 The block SHALL be one flat module with no sub-module.
REQ-039 The bench SHALL connect the block to peripheral_mpram_bb with matching ADDR_MSB/MEM_SIZE.

Verification
REQ-040 Write 0x0010 data 0xA55A be=11, then read 0x0010 -> read rsp_rdata=0xA55A, rsp_err=0, rsp_valid 3 cycles after accept.
REQ-041 Write 0x0020 0x1234 be=11, write 0x0020 0xFFFF be=01, read -> 0x12FF; repeat with be=10 on 0x1234 -> 0xFF34.
REQ-042 Read 0x0100 (word 128, MEM_SIZE=256) -> rsp_err=1, rsp_rdata=0, ram_cen never low, rsp_valid 1 cycle after accept.
REQ-043 Read with rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata held stable, req_ready=0 throughout, IDLE after the handshake.
REQ-044 puc_rst pulsed during CAPTURE -> next cycle all outputs at their reset values, no rsp_valid, next request served normally.
REQ-045 Write be=00 to 0x0004 -> ram_cen stays high, rsp_valid after 1 cycle, rsp_err=0; a later read of 0x0004 returns the old value.

Source files
------------

// File: rtl/peripheral_mpram_pkg.sv
// Shared types and constants for the 16-bit RAM request/response master and its RAM model.
package peripheral_mpram_pkg;

  localparam int         DATA_W       = 16;
  localparam logic [1:0] RAM_WEN_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/peripheral_mpram_bb.sv
// Synchronous single-port 16-bit RAM with byte write enables (active-low cen/wen).
// Read data appears one cycle after the sampling edge; accesses beyond MEM_SIZE are ignored.
module peripheral_mpram_bb
  import peripheral_mpram_pkg::*;
#(
  parameter int ADDR_MSB = 6,
  parameter int MEM_SIZE = 256
) (
  input  logic                ram_clk,
  input  logic [ADDR_MSB:0]   ram_addr,
  input  logic                ram_cen,
  input  logic [1:0]          ram_wen,
  input  logic [DATA_W-1:0]   ram_din,
  output logic [DATA_W-1:0]   ram_dout
);

  localparam logic [ADDR_MSB+1:0] WORDS = (ADDR_MSB+2)'(MEM_SIZE / 2);

  logic [DATA_W-1:0] mem [0:(2**(ADDR_MSB+1))-1];
  logic              in_range;

  assign in_range = {1'b0, ram_addr} < WORDS;

  always_ff @(posedge ram_clk) begin
    if (!ram_cen && in_range) begin
      if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
      if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      ram_dout <= mem[ram_addr];
    end
  end

endmodule

// File: rtl/peripheral_mpram_master.sv
// Single-outstanding request/response bridge onto a synchronous single-port RAM.
// Latency accept->rsp_valid: read 3, write 2, error/empty write 1; holds RESP until rsp_ready.
module peripheral_mpram_master
  import peripheral_mpram_pkg::*;
#(
  parameter int ADDR_MSB = 6,
  parameter int MEM_SIZE = 256
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_be,
  input  logic [ADDR_MSB+1:0] req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_MSB:0]   ram_addr,
  output logic                ram_cen,
  output logic [1:0]          ram_wen,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout
);

  localparam logic [ADDR_MSB+1:0] WORDS = (ADDR_MSB+2)'(MEM_SIZE / 2);

  state_t              state;
  logic [ADDR_MSB:0]   word;
  logic                out_of_range;
  logic                addr_lsb_unused;

  assign word            = req_addr[ADDR_MSB+1:1];
  assign addr_lsb_unused = req_addr[0];
  assign out_of_range    = {1'b0, word} >= WORDS;
  assign req_ready       = (state == ST_IDLE) & ~puc_rst;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state     <= ST_IDLE;
      ram_cen   <= 1'b1;
      ram_wen   <= RAM_WEN_NONE;
      ram_addr  <= '0;
      ram_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // RAM strobes are single-cycle pulses; address and data stay put so ram_dout is stable.
      ram_cen <= 1'b1;
      ram_wen <= RAM_WEN_NONE;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            ram_addr  <= word;
            ram_din   <= req_wdata;
            ram_wen   <= req_we ? ~req_be : RAM_WEN_NONE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (out_of_range) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we && req_be == 2'b00) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state   <= ST_ACCESS;
              ram_cen <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          // A write reaching ACCESS always has at least one byte enabled.
          if (ram_wen != RAM_WEN_NONE) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          rsp_rdata <= ram_dout;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_mpram_master.sv
// Randomized scoreboard bench for peripheral_mpram_master driving peripheral_mpram_bb.
module tb_peripheral_mpram_master;

  localparam int ADDR_MSB = 7;
  localparam int MEM_SIZE = 256;
  localparam int WORDS    = MEM_SIZE / 2;

  logic                mclk;
  logic                puc_rst;
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [1:0]          req_be;
  logic [ADDR_MSB+1:0] req_addr;
  logic [15:0]         req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [15:0]         rsp_rdata;
  logic                rsp_err;
  logic [ADDR_MSB:0]   ram_addr;
  logic                ram_cen;
  logic [1:0]          ram_wen;
  logic [15:0]         ram_din;
  logic [15:0]         ram_dout;

  peripheral_mpram_master #(.ADDR_MSB(ADDR_MSB), .MEM_SIZE(MEM_SIZE)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  peripheral_mpram_bb #(.ADDR_MSB(ADDR_MSB), .MEM_SIZE(MEM_SIZE)) ram (
    .ram_clk(mclk), .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          cen;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [15:0] model [WORDS];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          cen_cnt = 0;
  bit          in_rsp = 0;
  bit          hs_prev = 0;
  bit          hold_low = 0;

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response consumer: random backpressure unless a test holds it low.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge mclk);
      #1;
      rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expectation per response and checks it every cycle it is held.
  initial begin
    forever begin
      @(negedge mclk);
      if (puc_rst) begin
        in_rsp  = 0;
        hs_prev = 0;
      end else begin
        if (!ram_cen) cen_cnt++;
        if (hs_prev) begin
          check("rsp_valid_after_handshake", {31'b0, rsp_valid}, 0);
          hs_prev = 0;
        end
        if (rsp_valid) begin
          if (!in_rsp) begin
            if (sb.size() == 0) begin
              check("unexpected_rsp", 1, 0);
            end else begin
              cur    = sb.pop_front();
              in_rsp = 1;
              check("latency", cyc - acc_cyc + 1, cur.lat);
              check("ram_cen_low_cycles", cen_cnt, cur.cen);
            end
          end
          if (in_rsp) begin
            check("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, cur.rdata});
            check("rsp_err", {31'b0, rsp_err}, {31'b0, cur.err});
            check("req_ready_while_rsp", {31'b0, req_ready}, 0);
            if (rsp_ready) begin
              hs_prev = 1;
              in_rsp  = 0;
            end
          end
        end
        if (req_valid && req_ready) begin
          acc_cyc = cyc + 1;
          cen_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [1:0] be, input logic [8:0] addr,
                       input logic [15:0] wd);
    exp_t e;
    int   idx;
    int   n;
    idx     = int'(addr) >> 1;
    e.rdata = 16'h0;
    e.err   = 1'b0;
    if (idx >= WORDS) begin
      e.err = 1'b1; e.lat = 1; e.cen = 0;
    end else if (we && be == 2'b00) begin
      e.lat = 1; e.cen = 0;
    end else if (we) begin
      if (be[0]) model[idx][7:0]  = wd[7:0];
      if (be[1]) model[idx][15:8] = wd[15:8];
      e.lat = 2; e.cen = 1;
    end else begin
      e.rdata = model[idx]; e.lat = 3; e.cen = 1;
    end
    sb.push_back(e);
    @(posedge mclk);
    #1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge mclk);
      if (req_ready) break;
      if (++n > 500) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge mclk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 || in_rsp || rsp_valid) begin
      @(negedge mclk);
      if (++n > 2000) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 0);
    check({tag, "_ram_cen"},   {31'b0, ram_cen}, 1);
    check({tag, "_ram_wen"},   {30'b0, ram_wen}, 3);
    check({tag, "_ram_addr"},  {24'b0, ram_addr}, 0);
    check({tag, "_ram_din"},   {16'b0, ram_din}, 0);
    check({tag, "_rsp_rdata"}, {16'b0, rsp_rdata}, 0);
    check({tag, "_rsp_err"},   {31'b0, rsp_err}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    puc_rst   = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check_reset_outputs("reset");
    check("req_ready_in_reset", {31'b0, req_ready}, 0);
    @(posedge mclk);
    #1;
    puc_rst = 1'b0;
    @(negedge mclk);
    check("req_ready_after_reset", {31'b0, req_ready}, 1);

    for (int i = 0; i < WORDS; i++) issue(1'b1, 2'b11, 9'(i * 2), 16'($urandom));
    wait_idle();

    issue(1'b1, 2'b11, 9'h010, 16'hA55A);
    issue(1'b0, 2'b00, 9'h010, 16'h0);
    issue(1'b1, 2'b11, 9'h020, 16'h1234);
    issue(1'b1, 2'b01, 9'h020, 16'hFFFF);
    issue(1'b0, 2'b00, 9'h020, 16'h0);
    issue(1'b1, 2'b11, 9'h020, 16'h1234);
    issue(1'b1, 2'b10, 9'h020, 16'hFFFF);
    issue(1'b0, 2'b00, 9'h020, 16'h0);
    issue(1'b0, 2'b00, 9'h100, 16'h0);
    issue(1'b1, 2'b11, 9'h1FE, 16'hBEEF);
    issue(1'b1, 2'b11, 9'h004, 16'h5AA5);
    issue(1'b1, 2'b00, 9'h004, 16'hDEAD);
    issue(1'b0, 2'b00, 9'h004, 16'h0);
    issue(1'b0, 2'b00, 9'h0FF, 16'h0);
    wait_idle();

    hold_low = 1'b1;
    issue(1'b0, 2'b00, 9'h020, 16'h0);
    n = 0;
    while (!in_rsp && n < 100) begin
      @(negedge mclk);
      n++;
    end
    check("held_rsp_seen", {31'b0, in_rsp}, 1);
    repeat (5) @(posedge mclk);
    hold_low = 1'b0;
    wait_idle();

    for (int i = 0; i < 300; i++)
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            9'($urandom_range(0, 'h13F)), 16'($urandom));
    wait_idle();

    // Abort a read while it sits in CAPTURE.
    issue(1'b0, 2'b00, 9'h010, 16'h0);
    @(posedge mclk);
    #1;
    puc_rst = 1'b1;
    @(posedge mclk);
    #1;
    puc_rst = 1'b0;
    sb.delete();
    @(negedge mclk);
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge mclk);
    check("no_rsp_after_abort", {31'b0, rsp_valid}, 0);
    issue(1'b0, 2'b00, 9'h010, 16'h0);
    issue(1'b1, 2'b11, 9'h030, 16'h0F0F);
    issue(1'b0, 2'b00, 9'h030, 16'h0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
